// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Holds the arbiter FSM state type and the default packet-length and data widths
// used as parameter defaults by uart_tx_arbiter.
package uart_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_e;

   localparam int DEF_LEN_W = 5;
   localparam int DEF_D_BIT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req    - request vector, one bit per requester
//   rr_ptr - index of the requester that was served last
//   winner - one-hot winner; the search starts just after rr_ptr and wraps around
//            (all zeros when nothing is requested)
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int PTR_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner
);

   logic             found;
   logic [PTR_W-1:0] idx;

   // Walk the requesters in rotating order; the first one set wins.
   // The last candidate visited is rr_ptr itself, so a lone requester can win twice in a row.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one UART TX FIFO write port between
// NUM_REQ byte producers. A granted requester keeps the port until len bytes are written.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-low reset
//   req/req_len        - per-requester packet request and its byte count
//   req_data           - current byte offered by each requester
//   pop                - byte of the granted requester consumed this cycle
//   gnt/done/busy      - registered one-hot grant, completion pulse, transfer-active flag
//   full               - UART TX FIFO full (stalls the transfer)
//   write_en/write_data- UART TX FIFO write port
// Build option: define UART_ARB_HIPRI_EN to give requester 0 strict priority whenever
// the arbiter is idle; otherwise arbitration is pure round-robin.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int D_BIT   = DEF_D_BIT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic [NUM_REQ*D_BIT-1:0] req_data,
   output logic [NUM_REQ-1:0]       pop,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   input  logic                     full,
   output logic                     write_en,
   output logic [D_BIT-1:0]         write_data
);

   localparam int PTR_W = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               busy_q, busy_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;

   logic [NUM_REQ-1:0] rr_winner;
   logic [NUM_REQ-1:0] winner;
   logic [PTR_W-1:0]   g_idx;
   logic [D_BIT-1:0]   g_data;
   logic [LEN_W-1:0]   win_len;
   logic               finish;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (rr_winner)
   );

   // Optional strict priority for requester 0 overrides the rotating choice.
   always_comb begin
      winner = rr_winner;
`ifdef UART_ARB_HIPRI_EN
      if (req[0]) begin
         winner = NUM_REQ'(1);
      end
`endif
   end

   // Decode the one-hot grant into an index and the granted byte, and fetch the
   // packet length of the requester about to win.
   always_comb begin
      g_idx   = '0;
      g_data  = '0;
      win_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            g_idx  = PTR_W'(i);
            g_data = req_data[i*D_BIT +: D_BIT];
         end
         if (winner[i]) begin
            win_len = req_len[i*LEN_W +: LEN_W];
         end
      end
   end

   // Next-state and write-port logic. A zero-length packet finishes after a single
   // XFER cycle without writing; otherwise the packet ends on the write of its last byte.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      busy_d      = busy_q;
      rr_ptr_d    = rr_ptr_q;
      remaining_d = remaining_q;
      write_en    = 1'b0;
      write_data  = '0;
      pop         = '0;
      finish      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d       = winner;
               remaining_d = win_len;
               busy_d      = 1'b1;
               state_d     = ST_XFER;
            end
         end
         ST_XFER: begin
            if (remaining_q != '0) begin
               write_en = ~full;
               if (!full) begin
                  pop         = gnt_q;
                  write_data  = g_data;
                  remaining_d = remaining_q - LEN_W'(1);
               end
               finish = ~full && (remaining_q == LEN_W'(1));
            end else begin
               finish = 1'b1;
            end
            if (finish) begin
               done_d  = gnt_q;
               gnt_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
`ifdef UART_ARB_HIPRI_EN
               if (g_idx != '0) begin
                  rr_ptr_d = g_idx;
               end
`else
               rr_ptr_d = g_idx;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any packet in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         rr_ptr_q    <= rr_ptr_d;
         remaining_q <= remaining_d;
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, LEN_W=5, D_BIT=8).
// Each requester serves bytes from a table; a transaction-level model predicts the
// grant order and the byte stream of every packet, including FIFO-full stalls.
module tb_uart_tx_arbiter;

   localparam bit HIPRI =
`ifdef UART_ARB_HIPRI_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [19:0] req_len;
   logic [31:0] req_data;
   logic [3:0]  pop;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic        full;
   logic        write_en;
   logic [7:0]  write_data;

   logic [7:0]  mem [4][32];
   logic [4:0]  ptr [4];
   logic [4:0]  plen [4];

   int passCount;
   int totalCount;
   int failCount;
   int modelRr;

   uart_tx_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_len    (req_len),
      .req_data   (req_data),
      .pop        (pop),
      .gnt        (gnt),
      .done       (done),
      .busy       (busy),
      .full       (full),
      .write_en   (write_en),
      .write_data (write_data)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each requester presents the byte its table pointer selects, plus its packet length.
   always_comb begin
      req_data = '0;
      req_len  = '0;
      for (int i = 0; i < 4; i++) begin
         req_data[i*8 +: 8] = mem[i][ptr[i]];
         req_len[i*5 +: 5]  = plen[i];
      end
   end

   // One comparison: counts it, and reports observed versus expected on a miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: requester 0 first when priority is enabled, otherwise the
   // first pending requester after the one served last.
   function automatic int pickWinner(input logic [3:0] p);
      if (HIPRI && p[0]) return 0;
      for (int k = 1; k <= 4; k++) begin
         if (p[(modelRr + k) % 4]) return (modelRr + k) % 4;
      end
      return 0;
   endfunction

   task automatic loadData();
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 32; j++) mem[i][j] = 8'($urandom);
      end
   endtask

   // Follows one packet of requester who: grant in the first cycle, one byte per
   // non-full cycle in table order, then a single done pulse with the grant dropped.
   // fpat bit c forces full during packet cycle c.
   task automatic expectPacket(input int who, input int len, input logic [31:0] fpat);
      int   sent;
      int   c;
      logic popped;
      logic expWe;
      sent   = 0;
      c      = 0;
      popped = 1'b0;
      do begin
         @(negedge clk);
         if (popped) ptr[who] = ptr[who] + 5'd1;
         full = (c < 32) ? fpat[c] : 1'b0;
         #1;
         expWe = (sent < len) && !full;
         checkOutput("gnt", gnt, 32'(1) << who);
         checkOutput("busy", busy, 1);
         checkOutput("done_low", done, 0);
         checkOutput("write_en", write_en, expWe);
         checkOutput("pop", pop, expWe ? (32'(1) << who) : 0);
         checkOutput("write_data", write_data, expWe ? mem[who][sent] : 0);
         popped = pop[who];
         if (expWe) sent++;
         c++;
      end while (sent != len);
      @(negedge clk);
      if (popped) ptr[who] = ptr[who] + 5'd1;
      full = 1'b0;
      #1;
      checkOutput("done_pulse", done, 32'(1) << who);
      checkOutput("gnt_drop", gnt, 0);
      checkOutput("busy_drop", busy, 0);
      checkOutput("we_after", write_en, 0);
      checkOutput("pop_after", pop, 0);
      req[who] = 1'b0;
   endtask

   // Raises the given requests and follows every packet until none is pending;
   // requester 0 may re-request up to rearm0 more times right after its done pulse.
   task automatic applyStimulus(input logic [3:0] reqs, input int rearm0, input logic [31:0] fpat);
      logic [3:0] pending;
      int         who;
      int         rearmLeft;
      pending   = reqs;
      rearmLeft = rearm0;
      for (int i = 0; i < 4; i++) ptr[i] = '0;
      req = reqs;
      while (pending != 4'b0000) begin
         who = pickWinner(pending);
         expectPacket(who, int'(plen[who]), fpat);
         pending[who] = 1'b0;
         if (!(HIPRI && who == 0)) modelRr = who;
         if (who == 0 && rearmLeft > 0) begin
            rearmLeft--;
            pending[0] = 1'b1;
            ptr[0]     = '0;
            req[0]     = 1'b1;
         end
      end
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      failCount  = 0;
      modelRr    = 3;
      rst        = 1'b0;
      req        = '0;
      full       = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ptr[i]  = '0;
         plen[i] = '0;
      end
      loadData();

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_gnt", gnt, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_we", write_en, 0);
      checkOutput("rst_pop", pop, 0);
      checkOutput("rst_data", write_data, 0);
      rst = 1'b1;

      // All four requesters with two-byte packets, requester 0 asking again: 0,1,2,3,0
      for (int i = 0; i < 4; i++) plen[i] = 5'd2;
      applyStimulus(4'b1111, 1, 32'h0);

      // Single requester 0, three bytes 'A','B','C'
      plen[0]   = 5'd3;
      mem[0][0] = 8'h41;
      mem[0][1] = 8'h42;
      mem[0][2] = 8'h43;
      applyStimulus(4'b0001, 0, 32'h0);

      // Requester 1, four bytes, FIFO full during packet cycles 2-4
      loadData();
      plen[1] = 5'd4;
      applyStimulus(4'b0010, 0, 32'b1110);

      // Zero-length packet from requester 2
      plen[2] = 5'd0;
      applyStimulus(4'b0100, 0, 32'h0);

      // Requesters 0 and 1 with requester 0 asking repeatedly
      plen[0] = 5'd1;
      plen[1] = 5'd1;
      applyStimulus(4'b0011, 3, 32'h0);

      // Randomized request sets, lengths and stall patterns
      for (int it = 0; it < 8; it++) begin
         loadData();
         for (int i = 0; i < 4; i++) plen[i] = 5'($urandom_range(0, 9));
         applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(0, 1)), $urandom & $urandom);
      end

      // Reset in the middle of a five-byte packet after two bytes were written
      loadData();
      plen[1] = 5'd5;
      ptr[1]  = '0;
      req     = 4'b0010;
      @(negedge clk);
      #1;
      checkOutput("pre_rst_gnt", gnt, 4'b0010);
      @(negedge clk);
      ptr[1] = ptr[1] + 5'd1;
      @(negedge clk);
      ptr[1] = ptr[1] + 5'd1;
      #1;
      rst = 1'b0;
      #1;
      checkOutput("abort_gnt", gnt, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_we", write_en, 0);
      checkOutput("abort_pop", pop, 0);
      req = '0;
      @(negedge clk);
      rst     = 1'b1;
      modelRr = 3;
      loadData();
      plen[1] = 5'd3;
      applyStimulus(4'b0010, 0, 32'h0);

      // Quiet arbiter with nothing requested
      @(negedge clk);
      #1;
      checkOutput("idle_gnt", gnt, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_we", write_en, 0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
